// File: rtl/zmips_mdu_if.sv
// Request/result handshake bundle between the core pipeline and the multiply/divide unit.
interface zmips_mdu_if #(
  parameter int W = 32
);
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         flush;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;

  modport master (
    output req_valid, op, a, b, flush, res_ready,
    input  req_ready, res_valid, hi, lo, busy
  );

  modport slave (
    input  req_valid, op, a, b, flush, res_ready,
    output req_ready, res_valid, hi, lo, busy
  );
endinterface

// File: rtl/zmips_mdu.sv
// Iterative radix-2 multiply/divide unit: sign-magnitude operands, W shift steps, then a sign fix-up.
// All state advances on the falling clock edge to line up with the core pipeline registers.
module zmips_mdu #(
  parameter int W = 32
) (
  input  logic       clk,
  input  logic       rst,
  zmips_mdu_if.slave bus
);

  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t       state_q;
  logic [CW-1:0] cnt_q;
  logic         is_div_q;
  logic         neg_res_q;
  logic         neg_rem_q;
  logic [W-1:0] dvs_q;
  logic [W-1:0] acc_q;
  logic [W-1:0] mq_q;
  logic         res_valid_q;
  logic         busy_q;

  function automatic logic [W-1:0] mag_f(input logic signed [W-1:0] v, input logic neg);
    logic signed [W-1:0] r;
    r = neg ? -v : v;
    return $unsigned(r);
  endfunction

  function automatic logic [W-1:0] neg_w_f(input logic [W-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*W-1:0] neg_2w_f(input logic [2*W-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  logic signed [W-1:0] a_s;
  logic signed [W-1:0] b_s;
  logic                a_neg;
  logic                b_neg;
  logic                div_zero;

  assign a_s      = bus.a;
  assign b_s      = bus.b;
  assign a_neg    = bus.op[0] && (a_s < 0);
  assign b_neg    = bus.op[0] && (b_s < 0);
  assign div_zero = bus.op[1] && (bus.b == '0);

  logic [W-1:0]   addend;
  logic [W:0]     mul_sum;
  logic [W:0]     div_sh;
  logic [W:0]     div_diff;
  logic [W-1:0]   acc_d;
  logic [W-1:0]   mq_d;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   fix_hi_d;
  logic [W-1:0]   fix_lo_d;

  always_comb begin
    addend   = mq_q[0] ? dvs_q : '0;
    mul_sum  = {1'b0, acc_q} + {1'b0, addend};
    // Restoring step: the shifted remainder needs one extra bit before the trial subtract.
    div_sh   = {acc_q, mq_q[W-1]};
    div_diff = div_sh - {1'b0, dvs_q};
    acc_d    = mul_sum[W:1];
    mq_d     = {mul_sum[0], mq_q[W-1:1]};
    if (is_div_q) begin
      if (!div_diff[W]) begin
        acc_d = div_diff[W-1:0];
        mq_d  = {mq_q[W-2:0], 1'b1};
      end else begin
        acc_d = div_sh[W-1:0];
        mq_d  = {mq_q[W-2:0], 1'b0};
      end
    end
    prod_fix = neg_2w_f({acc_q, mq_q}, neg_res_q);
    fix_hi_d = prod_fix[2*W-1:W];
    fix_lo_d = prod_fix[W-1:0];
    if (is_div_q) begin
      fix_hi_d = neg_w_f(acc_q, neg_rem_q);
      fix_lo_d = neg_w_f(mq_q, neg_res_q);
    end
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      is_div_q    <= 1'b0;
      neg_res_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      dvs_q       <= '0;
      acc_q       <= '0;
      mq_q        <= '0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (bus.flush) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      mq_q        <= '0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            is_div_q <= bus.op[1];
            // Divide by zero skips iteration and reports all-ones quotient with the raw dividend.
            if (div_zero) begin
              state_q     <= DONE;
              acc_q       <= bus.a;
              mq_q        <= '1;
              res_valid_q <= 1'b1;
            end else begin
              state_q   <= CALC;
              acc_q     <= '0;
              mq_q      <= mag_f(a_s, a_neg);
              dvs_q     <= mag_f(b_s, b_neg);
              neg_res_q <= a_neg ^ b_neg;
              neg_rem_q <= a_neg;
            end
          end
        end
        CALC: begin
          acc_q <= acc_d;
          mq_q  <= mq_d;
          if (cnt_q == LAST) begin
            state_q <= FIX;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        FIX: begin
          acc_q       <= fix_hi_d;
          mq_q        <= fix_lo_d;
          state_q     <= DONE;
          res_valid_q <= 1'b1;
        end
        DONE: begin
          if (bus.res_ready) begin
            state_q     <= IDLE;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = ~busy_q;
  assign bus.busy      = busy_q;
  assign bus.res_valid = res_valid_q;
  assign bus.hi        = res_valid_q ? acc_q : '0;
  assign bus.lo        = res_valid_q ? mq_q : '0;

endmodule

// File: tb/tb_zmips_mdu.sv
// Directed bench for zmips_mdu at W=32: vector table plus handshake, flush and reset sequences.
module tb_zmips_mdu;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  zmips_mdu_if #(.W(32)) bus ();

  zmips_mdu #(.W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  vec_t vt [15];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Advance across one active (falling) edge and land just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string nm, input logic [1:0] op_v, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] eh, input logic [31:0] el,
                        input int lat, input bit release_res);
    int n;
    chk({nm, " req_ready"}, 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1;
    bus.op        = op_v;
    bus.a         = av;
    bus.b         = bv;
    tick();
    bus.req_valid = 1'b0;
    bus.a         = $urandom;
    bus.b         = $urandom;
    bus.op        = 2'($urandom_range(0, 3));
    n = 0;
    while (!bus.res_valid && n < 40) begin
      if (n == 5) chk({nm, " calc zero"}, {bus.hi, bus.lo}, 64'd0);
      tick();
      n++;
    end
    chk({nm, " latency"}, 64'(n), 64'(lat));
    chk({nm, " hi"}, 64'(bus.hi), 64'(eh));
    chk({nm, " lo"}, 64'(bus.lo), 64'(el));
    if (release_res) begin
      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;
      chk({nm, " release"}, 64'({bus.res_valid, bus.req_ready, bus.busy}), 64'b010);
      chk({nm, " cleared"}, {bus.hi, bus.lo}, 64'd0);
    end
  endtask

  initial begin
    bit seen;
    n_chk  = 0;
    n_fail = 0;
    vt[0]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33};
    vt[1]  = '{2'b01, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 33};
    vt[2]  = '{2'b00, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 33};
    vt[3]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 33};
    vt[4]  = '{2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
    vt[5]  = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33};
    vt[6]  = '{2'b10, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 0};
    vt[7]  = '{2'b10, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 33};
    vt[8]  = '{2'b11, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33};
    vt[9]  = '{2'b11, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 0};
    vt[10] = '{2'b10, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 33};
    vt[11] = '{2'b01, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0000, 33};
    vt[12] = '{2'b00, 32'h0000_0000, 32'h0000_3039, 32'h0000_0000, 32'h0000_0000, 33};
    vt[13] = '{2'b10, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 33};
    vt[14] = '{2'b11, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'h0000_0002, 33};

    rst           = 1'b0;
    bus.req_valid = 1'b0;
    bus.op        = 2'b00;
    bus.a         = '0;
    bus.b         = '0;
    bus.flush     = 1'b0;
    bus.res_ready = 1'b0;
    #2;
    chk("reset flags", 64'({bus.res_valid, bus.busy, bus.req_ready}), 64'b001);
    chk("reset data", {bus.hi, bus.lo}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    for (int i = 0; i < 15; i++) begin
      run_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].hi, vt[i].lo,
             vt[i].lat, 1'b1);
    end

    // Result held under back-pressure; a request offered meanwhile must be ignored.
    run_op("hold", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33, 1'b0);
    for (int i = 0; i < 10; i++) begin
      bus.req_valid = 1'b1;
      bus.op        = 2'b00;
      tick();
      chk($sformatf("hold flags %0d", i), 64'({bus.res_valid, bus.req_ready, bus.busy}), 64'b101);
      chk($sformatf("hold data %0d", i), {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    bus.req_valid = 1'b0;
    chk("done to idle no accept", 64'({bus.res_valid, bus.req_ready, bus.busy}), 64'b010);

    // Flush beats acceptance, then aborts a multiply at E0+10.
    bus.req_valid = 1'b1;
    bus.op        = 2'b00;
    bus.a         = 32'd6;
    bus.b         = 32'd7;
    bus.flush     = 1'b1;
    tick();
    chk("flush over accept", 64'({bus.busy, bus.req_ready}), 64'b01);
    bus.flush = 1'b0;
    tick();
    bus.req_valid = 1'b0;
    chk("flush seq accepted", 64'(bus.busy), 64'd1);
    repeat (9) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush to idle", 64'({bus.res_valid, bus.busy, bus.req_ready}), 64'b001);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      seen = seen | bus.res_valid | bus.busy;
    end
    chk("flush no result", 64'(seen), 64'd0);
    run_op("after flush", 2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 33, 1'b1);

    // Flush while a result waits in DONE discards it.
    run_op("flush done", 2'b10, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF, 0, 1'b0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush done flags", 64'({bus.res_valid, bus.busy}), 64'b00);
    chk("flush done data", {bus.hi, bus.lo}, 64'd0);

    // Asynchronous reset between edges in the middle of CALC.
    bus.req_valid = 1'b1;
    bus.op        = 2'b01;
    bus.a         = 32'hFFFF_FFFD;
    bus.b         = 32'd5;
    tick();
    bus.req_valid = 1'b0;
    repeat (5) tick();
    chk("pre-reset busy", 64'(bus.busy), 64'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("async reset flags", 64'({bus.res_valid, bus.busy, bus.req_ready}), 64'b001);
    chk("async reset data", {bus.hi, bus.lo}, 64'd0);
    tick();
    rst  = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      seen = seen | bus.res_valid | bus.busy;
    end
    chk("no stale result", 64'(seen), 64'd0);
    run_op("after reset", 2'b01, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 33, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
